// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for Pong: frame-gated movement enables, miss detection, scoring, match FSM.
// Build option: define PONG_ALTERNATE_SERVE_EN to alternate serve direction on every point.
module pong_match_ctrl #(
  parameter logic [9:0] LEFT_LIMIT   = 10'd2,
  parameter logic [9:0] RIGHT_LIMIT  = 10'd630,
  parameter logic [7:0] SERVE_FRAMES = 8'd60,
  parameter logic [7:0] POINT_FRAMES = 8'd30,
  parameter logic [3:0] WIN_SCORE    = 4'd7
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       endofframe,
  input  logic       start,
  input  logic [9:0] ball_x,
  output logic       move_en,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  // state    | meaning
  // IDLE     | power-up, ball held at centre, waiting for start
  // SERVE    | ball held at centre for SERVE_FRAMES frames
  // PLAY     | movement enabled, misses checked once per frame
  // POINT    | everything frozen for POINT_FRAMES frames after a miss
  // GAMEOVER | final score and winner held until start
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  state_t     cur;
  logic       start_q;
  logic [7:0] frame_cnt;
  logic       start_rise;

  assign start_rise = start & ~start_q;
  assign state      = cur;

  // start_q follows start even during reset so a button held through reset is not seen as a press
  always_ff @(posedge clk50M) begin
    start_q <= start;
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      cur       <= S_IDLE;
      move_en   <= 1'b0;
      ball_hold <= 1'b1;
      serve_dir <= 1'b0;
      score_one <= 4'd0;
      score_two <= 4'd0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      case (cur)
        S_IDLE, S_GAMEOVER: begin
          if (start_rise) begin
            cur       <= S_SERVE;
            score_one <= 4'd0;
            score_two <= 4'd0;
            winner    <= 1'b0;
            game_over <= 1'b0;
            serve_dir <= 1'b0;
            frame_cnt <= 8'd0;
            move_en   <= 1'b0;
            ball_hold <= 1'b1;
          end
        end
        S_SERVE: begin
          if (endofframe) begin
            if (frame_cnt == SERVE_FRAMES - 8'd1) begin
              cur       <= S_PLAY;
              frame_cnt <= 8'd0;
              move_en   <= 1'b1;
              ball_hold <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        S_PLAY: begin
          if (endofframe && (ball_x <= LEFT_LIMIT || ball_x >= RIGHT_LIMIT)) begin
            cur       <= S_POINT;
            frame_cnt <= 8'd0;
            move_en   <= 1'b0;
            ball_hold <= 1'b0;
            if (ball_x <= LEFT_LIMIT) begin
              score_one <= score_one + 4'd1;
`ifdef PONG_ALTERNATE_SERVE_EN
              serve_dir <= ~serve_dir;
`else
              serve_dir <= 1'b0;
`endif
            end else begin
              score_two <= score_two + 4'd1;
`ifdef PONG_ALTERNATE_SERVE_EN
              serve_dir <= ~serve_dir;
`else
              serve_dir <= 1'b1;
`endif
            end
          end
        end
        S_POINT: begin
          if (endofframe) begin
            if (frame_cnt == POINT_FRAMES - 8'd1) begin
              frame_cnt <= 8'd0;
              move_en   <= 1'b0;
              ball_hold <= 1'b1;
              if (score_one == WIN_SCORE) begin
                cur       <= S_GAMEOVER;
                game_over <= 1'b1;
                winner    <= 1'b0;
              end else if (score_two == WIN_SCORE) begin
                cur       <= S_GAMEOVER;
                game_over <= 1'b1;
                winner    <= 1'b1;
              end else begin
                cur <= S_SERVE;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          cur       <= S_IDLE;
          move_en   <= 1'b0;
          ball_hold <= 1'b1;
          game_over <= 1'b0;
          frame_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
